// File: rtl/clk_gate_ctrl_pkg.sv
// Shared types and constants for the clk_gate_ctrl power sequencer.
package clk_gate_ctrl_pkg;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    IDLE_CNT = 3'd1,
    SLEEP_HS = 3'd2,
    OFF      = 3'd3,
    WAKE     = 3'd4
  } clk_gate_state_e;

  localparam int unsigned GatedCntW = 32;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prim_clock_gating.sv
// Latch-based glitch-free clock gate; test_en_i keeps the clock running during scan.
module prim_clock_gating (
  input  logic clk_i,
  input  logic en_i,
  input  logic test_en_i,
  output logic clk_o
);

  logic en_latch;

  // Enable is captured only while the clock is low so clk_o never glitches.
  always_latch begin
    if (!clk_i) en_latch = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/clk_gate_ctrl.sv
// Sleep/wake sequencer owning the enable of one gated clock domain.
// Optional gated-cycle statistics counter under CLK_GATE_CTRL_STATS_EN.
module clk_gate_ctrl
  import clk_gate_ctrl_pkg::*;
#(
  parameter int unsigned NumReq     = 4,
  parameter int unsigned IdleCycles = 16,
  parameter int unsigned WakeCycles = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NumReq-1:0] req_i,
  input  logic              force_on_i,
  input  logic              idle_i,
  input  logic              sleep_ack_i,
  input  logic              test_en_i,
  output logic              sleep_req_o,
  output logic              clk_en_o,
  output logic              awake_o,
  output logic [2:0]        state_o,
`ifdef CLK_GATE_CTRL_STATS_EN
  output logic [GatedCntW-1:0] gated_cycles_o,
`endif
  output logic              clk_o
);

  localparam int unsigned CntMax = max_u(IdleCycles, WakeCycles);
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] IdleLoad = CntW'(IdleCycles - 1);
  localparam logic [CntW-1:0] WakeLoad = CntW'(WakeCycles - 1);

  clk_gate_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic clk_en_q, clk_en_d;
  logic awake_q, awake_d;
  logic sleep_req_q, sleep_req_d;
  logic wake, quiet;

  assign wake  = (|req_i) | force_on_i;
  assign quiet = !wake && idle_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      RUN: begin
        if (quiet) begin
          state_d = IDLE_CNT;
          cnt_d   = IdleLoad;
        end
      end
      IDLE_CNT: begin
        if (!quiet) begin
          state_d = RUN;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = SLEEP_HS;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      // A wake vote beats a simultaneous acknowledge: the handshake aborts.
      SLEEP_HS: begin
        if (wake)             state_d = RUN;
        else if (sleep_ack_i) state_d = OFF;
      end
      OFF: begin
        if (wake) begin
          state_d = WAKE;
          cnt_d   = WakeLoad;
        end
      end
      WAKE: begin
        if (cnt_q == '0) state_d = RUN;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    clk_en_d    = (state_d != OFF);
    awake_d     = (state_d == RUN) || (state_d == IDLE_CNT);
    sleep_req_d = (state_d == SLEEP_HS) || (state_d == OFF);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= RUN;
      cnt_q       <= '0;
      clk_en_q    <= 1'b1;
      awake_q     <= 1'b1;
      sleep_req_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      clk_en_q    <= clk_en_d;
      awake_q     <= awake_d;
      sleep_req_q <= sleep_req_d;
    end
  end

  assign state_o     = state_q;
  assign clk_en_o    = clk_en_q;
  assign awake_o     = awake_q;
  assign sleep_req_o = sleep_req_q;

`ifdef CLK_GATE_CTRL_STATS_EN
  logic [GatedCntW-1:0] gated_cnt_q, gated_cnt_d;

  always_comb begin
    gated_cnt_d = gated_cnt_q;
    if ((state_q == OFF) && (gated_cnt_q != '1)) gated_cnt_d = gated_cnt_q + GatedCntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) gated_cnt_q <= '0;
    else       gated_cnt_q <= gated_cnt_d;
  end

  assign gated_cycles_o = gated_cnt_q;
`endif

  prim_clock_gating u_cg (
    .clk_i     (clk_i),
    .en_i      (clk_en_q),
    .test_en_i (test_en_i),
    .clk_o     (clk_o)
  );

endmodule
